// File: rtl/systolic_feeder_pkg.sv
// Shared types and constants for the systolic array feeder.
// Holds the controller state encoding and the bank geometry.
package systolic_feeder_pkg;

    localparam int nRows = 3;
    localparam int nCols = 4;

    typedef enum logic [2:0] {
        IDLE,
        BN_LOAD,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

    // Counter width for a modulo-n count; a 1-bit counter for degenerate n.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Handshake and bank-side bus of the systolic feeder.
// The master side is the launching controller; the slave side is the feeder.
interface systolic_feeder_if #(
    parameter int iWidth = 8,
    parameter int nRows  = 3
);

    logic                    start;
    logic                    abort;
    logic                    bn_load;
    logic [7:0]              cfg_len;
    logic                    bn_cfg_valid;
    logic                    bn_cfg_ready;
    logic [15:0]             bn_cfg_data;
    logic                    s_valid;
    logic                    s_ready;
    logic [nRows*iWidth-1:0] s_data;
    logic                    in_en;
    logic                    active_1;
    logic                    active_2;
    logic                    active_3;
    logic [iWidth-1:0]       data_in_horz_1;
    logic [iWidth-1:0]       data_in_horz_2;
    logic [iWidth-1:0]       data_in_horz_3;
    logic [15:0]             bn_param_in;
    logic                    bn_param_in_en;
    logic                    busy;
    logic                    done;

    modport master (
        output start, abort, bn_load, cfg_len,
        output bn_cfg_valid, bn_cfg_data, s_valid, s_data,
        input  bn_cfg_ready, s_ready, in_en,
        input  active_1, active_2, active_3,
        input  data_in_horz_1, data_in_horz_2, data_in_horz_3,
        input  bn_param_in, bn_param_in_en, busy, done
    );

    modport slave (
        input  start, abort, bn_load, cfg_len,
        input  bn_cfg_valid, bn_cfg_data, s_valid, s_data,
        output bn_cfg_ready, s_ready, in_en,
        output active_1, active_2, active_3,
        output data_in_horz_1, data_in_horz_2, data_in_horz_3,
        output bn_param_in, bn_param_in_en, busy, done
    );

endinterface

// File: rtl/systolic_feeder_skew_line.sv
// Fixed-depth valid/data delay line used to skew one bank row.
// Invalid beats are stored as zero data so bubbles reach the bank clean.
module skew_line
    import systolic_feeder_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] data_out
);

    logic             vld_p  [DEPTH];
    logic [WIDTH-1:0] data_p [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_p[i]  <= 1'b0;
                data_p[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_p[i]  <= 1'b0;
                data_p[i] <= '0;
            end
        end else begin
            // stage 0 captures the accepted beat, later stages shift
            vld_p[0]  <= vld_in;
            data_p[0] <= vld_in ? data_in : '0;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i]  <= vld_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign vld_out  = vld_p[DEPTH-1];
    assign data_out = data_p[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Feeds skewed row data and BN parameter words into a 3-row systolic bank.
// Controller: optional BN load, counted stream, fixed drain, one-cycle done.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int iWidth    = 8,
    parameter int nRows     = 3,
    parameter int nCols     = 4,
    parameter int DRAIN_CYC = 6
) (
    input logic              clk,
    input logic              rst,
    systolic_feeder_if.slave bus
);

    localparam int BN_CNT_W  = cnt_width(nCols);
    localparam int DRAIN_LEN = 2 + DRAIN_CYC;
    localparam int DR_W      = cnt_width(DRAIN_LEN);

    feeder_state_t       state;
    logic [7:0]          len_q;
    logic [7:0]          beat_cnt;
    logic [BN_CNT_W-1:0] bn_cnt;
    logic [DR_W-1:0]     drain_cnt;
    logic                s_ready_q;
    logic                bn_ready_q;
    logic                busy_q;
    logic                done_q;
    logic [15:0]         bn_word_q;
    logic                bn_en_q;

    logic s_acc;
    logic bn_acc;

    // abort wins over both handshakes, so a beat offered with abort is dropped
    assign s_acc  = bus.s_valid && s_ready_q && !bus.abort;
    assign bn_acc = bus.bn_cfg_valid && bn_ready_q && !bus.abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            len_q      <= '0;
            beat_cnt   <= '0;
            bn_cnt     <= '0;
            drain_cnt  <= '0;
            s_ready_q  <= 1'b0;
            bn_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bn_word_q  <= '0;
            bn_en_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            bn_en_q <= 1'b0;
            if (bus.abort) begin
                state      <= IDLE;
                beat_cnt   <= '0;
                bn_cnt     <= '0;
                drain_cnt  <= '0;
                s_ready_q  <= 1'b0;
                bn_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                bn_word_q  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            len_q    <= bus.cfg_len;
                            beat_cnt <= '0;
                            bn_cnt   <= '0;
                            busy_q   <= 1'b1;
                            if (bus.bn_load) begin
                                state      <= BN_LOAD;
                                bn_ready_q <= 1'b1;
                            end else if (bus.cfg_len != 8'd0) begin
                                state     <= STREAM;
                                s_ready_q <= 1'b1;
                            end else begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    BN_LOAD: begin
                        if (bn_acc) begin
                            bn_word_q <= bus.bn_cfg_data;
                            bn_en_q   <= 1'b1;
                            if (bn_cnt == BN_CNT_W'(nCols - 1)) begin
                                bn_cnt     <= '0;
                                bn_ready_q <= 1'b0;
                                if (len_q != 8'd0) begin
                                    state     <= STREAM;
                                    s_ready_q <= 1'b1;
                                end else begin
                                    state  <= DONE;
                                    done_q <= 1'b1;
                                end
                            end else begin
                                bn_cnt <= bn_cnt + 1'b1;
                            end
                        end
                    end
                    STREAM: begin
                        if (s_acc) begin
                            if (beat_cnt == len_q - 8'd1) begin
                                state     <= DRAIN;
                                s_ready_q <= 1'b0;
                                beat_cnt  <= '0;
                                drain_cnt <= '0;
                            end else begin
                                beat_cnt <= beat_cnt + 8'd1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == DR_W'(DRAIN_LEN - 1)) begin
                            state     <= DONE;
                            done_q    <= 1'b1;
                            drain_cnt <= '0;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    logic             row_vld  [nRows];
    logic [iWidth-1:0] row_data [nRows];

    // row r is delayed r+1 cycles after acceptance
    for (genvar r = 0; r < nRows; r++) begin : g_row
        skew_line #(
            .DEPTH(r + 1),
            .WIDTH(iWidth)
        ) u_skew (
            .clk     (clk),
            .rst     (rst),
            .clr     (bus.abort),
            .vld_in  (s_acc),
            .data_in (bus.s_data[r*iWidth +: iWidth]),
            .vld_out (row_vld[r]),
            .data_out(row_data[r])
        );
    end

    assign bus.in_en          = row_vld[0];
    assign bus.active_1       = row_vld[0];
    assign bus.active_2       = row_vld[1];
    assign bus.active_3       = row_vld[2];
    assign bus.data_in_horz_1 = row_data[0];
    assign bus.data_in_horz_2 = row_data[1];
    assign bus.data_in_horz_3 = row_data[2];
    assign bus.s_ready        = s_ready_q;
    assign bus.bn_cfg_ready   = bn_ready_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.bn_param_in    = bn_word_q;
    assign bus.bn_param_in_en = bn_en_q;

endmodule
